// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// Frames each transaction with chip-select setup/hold gaps and returns the read word with a one-cycle ack.
module spi_txn_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [32*NUM_REQ-1:0]  wdata_i,
  input  logic [3*NUM_REQ-1:0]   nbytes_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic                   err_o,
  output logic [31:0]            rdata_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic [NUM_REQ-1:0]     cs_n_o,
  output logic                   enable_o,
  output logic [31:0]            write_data_o,
  output logic [2:0]             write_bytes_o,
  input  logic                   master_busy_i,
  input  logic [31:0]            read_data_i,
  input  logic [2:0]             read_bytes_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SU_W  = $clog2(CS_SETUP + 1);
  localparam int HO_W  = $clog2(CS_HOLD + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(CS_SETUP - 1);
  localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(CS_HOLD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   rr_q;
  logic [PTR_W-1:0]   gidx_q;
  logic [2:0]         nb_q;
  logic               err_q;
  logic [31:0]        word_q;
  logic [SU_W-1:0]    su_cnt_q;
  logic [HO_W-1:0]    ho_cnt_q;
  logic [TO_W-1:0]    to_cnt_q;

  logic [31:0]        wd_a [NUM_REQ];
  logic [2:0]         nb_a [NUM_REQ];

  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic [2:0]         pick_nb;
  logic               pick_bad;
  int                 pick_j;
  logic               capture;
  logic [31:0]        word_nxt;
  logic [2:0]         nb_m1;
  logic [PTR_W-1:0]   rr_nxt;

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
    assign wd_a[n] = wdata_i[32*n +: 32];
    assign nb_a[n] = nbytes_i[3*n +: 3];
  end

  // Walk from the highest offset down so the lowest offset after rr_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_j   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pick_j = int'(rr_q) + i;
      if (pick_j >= NUM_REQ) pick_j = pick_j - NUM_REQ;
      if (req_i[pick_j]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(pick_j);
      end
    end
  end

  assign pick_oh  = NUM_REQ'(1) << pick_idx;
  assign pick_nb  = nb_a[pick_idx];
  assign pick_bad = (pick_nb == 3'd0) || (pick_nb > 3'd4);

  // The master may clear its read word when it goes idle, so keep the last non-empty one.
  assign capture  = ((state_q == RUN) || (state_q == HOLD)) && (read_bytes_i != 3'd0);
  assign word_nxt = capture ? read_data_i : word_q;
  assign nb_m1    = nb_q - 3'd1;
  assign rr_nxt   = (gidx_q == PTR_LAST) ? '0 : gidx_q + PTR_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      gidx_q        <= '0;
      nb_q          <= '0;
      err_q         <= 1'b0;
      word_q        <= '0;
      su_cnt_q      <= '0;
      ho_cnt_q      <= '0;
      to_cnt_q      <= '0;
      ack_o         <= '0;
      err_o         <= 1'b0;
      rdata_o       <= '0;
      grant_o       <= '0;
      cs_n_o        <= '1;
      enable_o      <= 1'b0;
      write_data_o  <= '0;
      write_bytes_o <= '0;
    end else begin
      ack_o  <= '0;
      word_q <= word_nxt;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gidx_q  <= pick_idx;
            grant_o <= pick_oh;
            nb_q    <= pick_nb;
            word_q  <= '0;
            if (pick_bad) begin
              ack_o   <= pick_oh;
              err_o   <= 1'b1;
              rdata_o <= '0;
              state_q <= DONE;
            end else begin
              err_q         <= 1'b0;
              cs_n_o        <= ~pick_oh;
              write_data_o  <= wd_a[pick_idx];
              write_bytes_o <= pick_nb;
              state_q       <= SETUP;
            end
          end
        end
        SETUP: begin
          if (su_cnt_q == SU_LAST) begin
            su_cnt_q <= '0;
            enable_o <= 1'b1;
            state_q  <= START;
          end else begin
            su_cnt_q <= su_cnt_q + SU_W'(1);
          end
        end
        START: begin
          if (master_busy_i) begin
            to_cnt_q <= '0;
            state_q  <= RUN;
          end else if (to_cnt_q == TO_LAST) begin
            to_cnt_q <= '0;
            enable_o <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= HOLD;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        RUN: begin
          // Drop enable once the last byte is underway so the master stops after it.
          if (read_bytes_i >= nb_m1) enable_o <= 1'b0;
          if (!master_busy_i) begin
            enable_o <= 1'b0;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (ho_cnt_q == HO_LAST) begin
            ho_cnt_q <= '0;
            cs_n_o   <= '1;
            ack_o    <= grant_o;
            err_o    <= err_q;
            rdata_o  <= err_q ? 32'd0 : word_nxt;
            state_q  <= DONE;
          end else begin
            ho_cnt_q <= ho_cnt_q + HO_W'(1);
          end
        end
        DONE: begin
          grant_o <= '0;
          rr_q    <= rr_nxt;
          state_q <= IDLE;
        end
        default: begin
          enable_o <= 1'b0;
          cs_n_o   <= '1;
          grant_o  <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a small behavioural SPI master model.
module tb_spi_txn_arbiter;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic [3:0]   req_i;
  logic [127:0] wdata_i;
  logic [11:0]  nbytes_i;
  logic [3:0]   ack_o;
  logic         err_o;
  logic [31:0]  rdata_o;
  logic [3:0]   grant_o;
  logic [3:0]   cs_n_o;
  logic         enable_o;
  logic [31:0]  write_data_o;
  logic [2:0]   write_bytes_o;
  logic         master_busy_i;
  logic [31:0]  read_data_i;
  logic [2:0]   read_bytes_i;

  spi_txn_arbiter #(
    .NUM_REQ (4),
    .CS_SETUP(4),
    .CS_HOLD (4),
    .TIMEOUT (16)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .req_i        (req_i),
    .wdata_i      (wdata_i),
    .nbytes_i     (nbytes_i),
    .ack_o        (ack_o),
    .err_o        (err_o),
    .rdata_o      (rdata_o),
    .grant_o      (grant_o),
    .cs_n_o       (cs_n_o),
    .enable_o     (enable_o),
    .write_data_o (write_data_o),
    .write_bytes_o(write_bytes_o),
    .master_busy_i(master_busy_i),
    .read_data_i  (read_data_i),
    .read_bytes_i (read_bytes_i)
  );

  always #5 clk_i = ~clk_i;

  // Master model: goes busy on enable, fills one byte every 3 cycles, returns word mst_word+level,
  // and clears its outputs when it returns to idle.
  logic        mst_en;
  logic [31:0] mst_word;
  int          mst_tick;

  always @(negedge clk_i) begin
    if (!rstn_i || !mst_en) begin
      master_busy_i = 1'b0;
      read_bytes_i  = 3'd0;
      read_data_i   = 32'd0;
      mst_tick      = 0;
    end else if (!master_busy_i) begin
      if (enable_o) begin
        master_busy_i = 1'b1;
        read_bytes_i  = 3'd0;
        mst_tick      = 0;
      end
    end else if (read_bytes_i == write_bytes_o) begin
      if (!enable_o) begin
        master_busy_i = 1'b0;
        read_bytes_i  = 3'd0;
        read_data_i   = 32'd0;
      end
    end else begin
      mst_tick = mst_tick + 1;
      if (mst_tick == 3) begin
        mst_tick     = 0;
        read_bytes_i = read_bytes_i + 3'd1;
        read_data_i  = mst_word + {29'd0, read_bytes_i};
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, need 0x%0h", nm, act, exp);
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {
    int          idx;
    logic [31:0] wdata;
    logic [2:0]  nb;
    logic [31:0] mword;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [6];

  // One request from v.idx; watches the whole frame and checks the ack.
  task automatic run_txn(input vec_t v, input bit tmo);
    bit          done, en_seen, fell, cs_any, wd_bad, sel_bad;
    int          setup_cnt, en_cycles, hold_cnt;
    logic [2:0]  rb_at_fall;
    logic        busy_at_fall;
    logic [3:0]  ackv;
    logic        errv;
    logic [31:0] rdv;
    logic [3:0]  oh;
    done = 0; en_seen = 0; fell = 0; cs_any = 0; wd_bad = 0; sel_bad = 0;
    setup_cnt = 0; en_cycles = 0; hold_cnt = 0;
    rb_at_fall = 3'd7; busy_at_fall = 1'b0;
    ackv = '0; errv = 1'b0; rdv = '0;
    oh = 4'b0001 << v.idx;
    mst_word = v.mword;
    wdata_i[32*v.idx +: 32] = v.wdata;
    nbytes_i[3*v.idx +: 3]  = v.nb;
    req_i = oh;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk_i); #1;
      if (cs_n_o != 4'hF) cs_any = 1;
      if (cs_n_o != 4'hF && cs_n_o != ~oh) sel_bad = 1;
      if (grant_o != 4'h0 && grant_o != oh) sel_bad = 1;
      if (!en_seen && !enable_o && cs_n_o != 4'hF) setup_cnt++;
      if (enable_o) begin
        en_seen = 1;
        en_cycles++;
      end else if (en_seen && !fell) begin
        fell = 1;
        rb_at_fall = read_bytes_i;
        busy_at_fall = master_busy_i;
      end
      if (fell && !enable_o && cs_n_o != 4'hF) hold_cnt++;
      if (cs_n_o != 4'hF && (write_data_o != v.wdata || write_bytes_o != v.nb)) wd_bad = 1;
      if (ack_o != 4'h0) begin
        done = 1;
        ackv = ack_o;
        errv = err_o;
        rdv  = rdata_o;
        req_i = 4'h0;
      end
    end
    if (!done) req_i = 4'h0;
    chk($sformatf("ack_seen[%0d]", v.idx), 64'(done), 64'(1));
    chk($sformatf("ack_who[%0d]", v.idx), 64'(ackv), 64'(oh));
    chk($sformatf("err[%0d]", v.idx), 64'(errv), 64'(v.err));
    chk($sformatf("rdata[%0d]", v.idx), 64'(rdv), 64'(v.rdata));
    chk($sformatf("owner_sel[%0d]", v.idx), 64'(sel_bad), 64'(0));
    if (v.nb == 3'd0 || v.nb > 3'd4) begin
      chk("illegal_cs", 64'(cs_any), 64'(0));
      chk("illegal_en", 64'(en_seen), 64'(0));
    end else begin
      chk("setup_cycles", 64'(setup_cnt), 64'(4));
      chk("wdata_held", 64'(wd_bad), 64'(0));
      if (tmo) begin
        chk("tmo_en_cycles", 64'(en_cycles), 64'(16));
        chk("tmo_hold_cycles", 64'(hold_cnt), 64'(4));
      end else begin
        chk("rb_at_en_fall", 64'(rb_at_fall), 64'(v.nb - 3'd1));
        chk("busy_at_en_fall", 64'(busy_at_fall), 64'(1));
      end
    end
  endtask

  initial begin
    vec_t tv;
    int   fair_exp [5];
    int   nack, viol, ack_after_rst;
    bit   found;

    vecs[0] = '{3, 32'h0000BEEF, 3'd2, 32'h55AA0000, 1'b0, 32'h55AA0002};
    vecs[1] = '{0, 32'h000000A5, 3'd1, 32'h12345600, 1'b0, 32'h12345601};
    vecs[2] = '{2, 32'h11112222, 3'd0, 32'h77770000, 1'b1, 32'h00000000};
    vecs[3] = '{2, 32'h33334444, 3'd5, 32'h77770000, 1'b1, 32'h00000000};
    vecs[4] = '{3, 32'h0BADF00D, 3'd3, 32'h0F0F0F00, 1'b0, 32'h0F0F0F03};
    vecs[5] = '{1, 32'hDEADBEEF, 3'd4, 32'hCAFE0000, 1'b0, 32'hCAFE0004};
    fair_exp = '{0, 1, 2, 3, 0};

    rstn_i = 1'b0; req_i = 4'h0; wdata_i = '0; nbytes_i = '0;
    mst_en = 1'b1; mst_word = 32'd0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_cs", 64'(cs_n_o), 64'hF);
    chk("rst_ctrl", 64'({ack_o, err_o, enable_o}), 64'(0));
    chk("rst_data", 64'({rdata_o, write_data_o}), 64'(0));
    chk("rst_wbytes", 64'(write_bytes_o), 64'(0));
    rstn_i = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0);

    // Master never answers: START must give up after TIMEOUT cycles.
    mst_en = 1'b0;
    tv = '{1, 32'h13579BDF, 3'd2, 32'h0, 1'b1, 32'h0};
    run_txn(tv, 1'b1);
    mst_en = 1'b1;

    // Reset while requester 2 is shifting (rr pointer is 2 here).
    mst_word = 32'hABCD0000;
    wdata_i[64 +: 32] = 32'h11223344;
    nbytes_i[6 +: 3]  = 3'd4;
    req_i = 4'b0100;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk_i); #1;
      if (enable_o && master_busy_i) found = 1;
    end
    chk("reached_run", 64'(found), 64'(1));
    rstn_i = 1'b0;
    req_i = 4'h0;
    @(posedge clk_i); #1;
    chk("abort_en", 64'(enable_o), 64'(0));
    chk("abort_cs", 64'(cs_n_o), 64'hF);
    chk("abort_grant", 64'(grant_o), 64'(0));
    chk("abort_ack", 64'(ack_o), 64'(0));
    rstn_i = 1'b1;
    ack_after_rst = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_i); #1;
      if (ack_o != 4'h0) ack_after_rst++;
    end
    chk("no_ack_after_abort", 64'(ack_after_rst), 64'(0));

    // All four requesting continuously: order must start at 0 after reset.
    mst_word = 32'h0BAD0000;
    nbytes_i = {4{3'd1}};
    wdata_i  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    req_i = 4'hF;
    nack = 0; viol = 0;
    for (int c = 0; c < 3000 && nack < 5; c++) begin
      @(posedge clk_i); #1;
      if ($countones(~cs_n_o) > 1 || $countones(grant_o) > 1) viol++;
      if (ack_o != 4'h0) begin
        chk($sformatf("fair_order[%0d]", nack), 64'(oh_idx(ack_o)), 64'(fair_exp[nack]));
        chk($sformatf("fair_err[%0d]", nack), 64'(err_o), 64'(0));
        chk($sformatf("fair_rdata[%0d]", nack), 64'(rdata_o), 64'h0BAD0001);
        nack++;
      end
    end
    req_i = 4'h0;
    chk("fair_acks", 64'(nack), 64'(5));
    chk("one_cs_low", 64'(viol), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
